nvic_exc_ctrl: RTL and testbench

Exception-entry sequencer between the NVIC and the Cortex-M0 core.
- Takes the NVIC's per-IRQ active/pending vector and the priority register, and selects the winning IRQ.
- Compares the winner against the current execution priority and runs a request/acknowledge handshake with the core.
- Keeps a nesting stack of active handlers and pulses clear-pending back into the NVIC ICPR path on entry.

---
 rtl/nvic_pkg.sv | 26 ++
 rtl/nvic_prio_arb.sv | 30 +++
 rtl/nvic_exc_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_nvic_exc_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvic_pkg.sv
// rtl/nvic_pkg.sv - shared constants for the NVIC exception-entry sequencer
package nvic_pkg;

  // Default configuration of the sequencer
  localparam int DEF_N_IRQ      = 8;
  localparam int DEF_PRIO_W     = 4;
  localparam int DEF_NEST_DEPTH = 4;

  // Width of the IRQ number carried on exc_num and in stack entries
  localparam int EXC_NUM_W = 3;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_POP  = 2'd3;

  // Execution priority of thread mode: one above every programmable level
  localparam logic [DEF_PRIO_W:0] THREAD_PRIO = 5'h10;

  // A stack entry holds the interrupted {exec_prio, exc_num}
  function automatic int stack_entry_w(input int prio_w);
    return prio_w + 1 + EXC_NUM_W;
  endfunction

endpackage

// File: rtl/nvic_prio_arb.sv
// rtl/nvic_prio_arb.sv - combinational lowest-priority-value IRQ arbiter
module nvic_prio_arb
  import nvic_pkg::*;
#(
  parameter int N_IRQ  = DEF_N_IRQ,
  parameter int PRIO_W = DEF_PRIO_W
) (
  input  logic [N_IRQ-1:0]        irq_pending_i,
  input  logic [N_IRQ*PRIO_W-1:0] irq_prio_i,
  output logic [EXC_NUM_W-1:0]    winner_o,
  output logic [PRIO_W-1:0]       win_prio_o,
  output logic                    any_pending_o
);

  // Ascending scan with strict compare so equal priorities keep the lowest index
  always_comb begin
    winner_o      = '0;
    win_prio_o    = '1;
    any_pending_o = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irq_pending_i[i] &&
          (!any_pending_o || (irq_prio_i[i*PRIO_W +: PRIO_W] < win_prio_o))) begin
        winner_o      = EXC_NUM_W'(i);
        win_prio_o    = irq_prio_i[i*PRIO_W +: PRIO_W];
        any_pending_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nvic_exc_ctrl.sv
// rtl/nvic_exc_ctrl.sv - exception-entry sequencer with nesting stack (option: NVIC_EXC_ERR_EN)
module nvic_exc_ctrl
  import nvic_pkg::*;
#(
  parameter int N_IRQ      = DEF_N_IRQ,
  parameter int PRIO_W     = DEF_PRIO_W,
  parameter int NEST_DEPTH = DEF_NEST_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_IRQ-1:0]        irq_pending_i,
  input  logic [N_IRQ*PRIO_W-1:0] irq_prio_i,
  input  logic                    exc_ack_i,
  input  logic                    exc_return_i,
  output logic                    exc_req_o,
  output logic [EXC_NUM_W-1:0]    exc_num_o,
  output logic [N_IRQ-1:0]        clr_pend_o,
  output logic [PRIO_W:0]         exec_prio_o,
  output logic [2:0]              nest_depth_o
`ifdef NVIC_EXC_ERR_EN
  ,
  output logic                    exc_err_o
`endif
);

  localparam int ENT_W = stack_entry_w(PRIO_W);
  localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [PRIO_W:0] THREAD_LVL = {1'b1, {PRIO_W{1'b0}}};
  localparam logic [2:0]      NEST_MAX   = 3'(NEST_DEPTH);

  logic [1:0]             state_q, state_d;
  logic [EXC_NUM_W-1:0]   req_num_q, req_num_d;
  logic [PRIO_W-1:0]      req_prio_q, req_prio_d;
  logic [EXC_NUM_W-1:0]   cur_num_q, cur_num_d;
  logic [PRIO_W:0]        exec_prio_q, exec_prio_d;
  logic [2:0]             nest_q, nest_d;
  logic [N_IRQ-1:0]       clr_pend_q, clr_pend_d;
  logic [ENT_W-1:0]       stack_q [NEST_DEPTH];

  logic                   push;
  logic [IDX_W-1:0]       push_idx;
  logic [IDX_W-1:0]       pop_idx;
  logic [ENT_W-1:0]       top_entry;

  logic [EXC_NUM_W-1:0]   winner;
  logic [PRIO_W-1:0]      win_prio;
  logic                   any_pending;
  logic                   prio_beats;
  logic                   stack_room;
  logic                   win_ok;

  nvic_prio_arb #(
    .N_IRQ  (N_IRQ),
    .PRIO_W (PRIO_W)
  ) u_arb (
    .irq_pending_i (irq_pending_i),
    .irq_prio_i    (irq_prio_i),
    .winner_o      (winner),
    .win_prio_o    (win_prio),
    .any_pending_o (any_pending)
  );

  // Entry is allowed only for a strictly more urgent IRQ while a stack slot is free
  always_comb begin
    prio_beats = any_pending && ({1'b0, win_prio} < exec_prio_q);
    stack_room = nest_q < NEST_MAX;
    win_ok     = prio_beats && stack_room;
    push_idx   = nest_q[IDX_W-1:0];
    pop_idx    = push_idx - 1'b1;
    top_entry  = stack_q[pop_idx];
  end

  // Sequencer next-state: request, acknowledge/withdraw, return and pop handling
  always_comb begin
    state_d     = state_q;
    req_num_d   = req_num_q;
    req_prio_d  = req_prio_q;
    cur_num_d   = cur_num_q;
    exec_prio_d = exec_prio_q;
    nest_d      = nest_q;
    clr_pend_d  = '0;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_ok) begin
          state_d    = ST_REQ;
          req_num_d  = winner;
          req_prio_d = win_prio;
        end
      end
      ST_REQ: begin
        // Ack beats a same-cycle pending drop; the request target never changes
        if (exc_ack_i) begin
          push                  = 1'b1;
          exec_prio_d           = {1'b0, req_prio_q};
          cur_num_d             = req_num_q;
          nest_d                = nest_q + 3'd1;
          clr_pend_d[req_num_q] = 1'b1;
          state_d               = ST_RUN;
        end else if (!irq_pending_i[req_num_q]) begin
          state_d = (nest_q != 3'd0) ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        // Return outranks a simultaneous preemption
        if (exc_return_i) begin
          exec_prio_d = top_entry[ENT_W-1 -: PRIO_W+1];
          cur_num_d   = top_entry[EXC_NUM_W-1:0];
          nest_d      = nest_q - 3'd1;
          state_d     = ST_POP;
        end else if (win_ok) begin
          state_d    = ST_REQ;
          req_num_d  = winner;
          req_prio_d = win_prio;
        end
      end
      ST_POP: begin
        state_d = (nest_q == 3'd0) ? ST_IDLE : ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset abandons any handshake in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      req_num_q   <= '0;
      req_prio_q  <= '0;
      cur_num_q   <= '0;
      exec_prio_q <= THREAD_LVL;
      nest_q      <= 3'd0;
      clr_pend_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_num_q   <= req_num_d;
      req_prio_q  <= req_prio_d;
      cur_num_q   <= cur_num_d;
      exec_prio_q <= exec_prio_d;
      nest_q      <= nest_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  // Nesting stack: saves the interrupted context on each accepted entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (push) begin
      stack_q[push_idx] <= {exec_prio_q, cur_num_q};
    end
  end

`ifdef NVIC_EXC_ERR_EN
  logic err_evt;
  logic exc_err_q;

  // Protocol misuse and preemptions lost to a full stack
  always_comb begin
    err_evt = ((state_q == ST_IDLE) && exc_return_i) ||
              ((state_q != ST_REQ) && exc_ack_i) ||
              ((state_q == ST_RUN) && !exc_return_i && prio_beats && !stack_room);
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exc_err_q <= 1'b0;
    end else if (err_evt) begin
      exc_err_q <= 1'b1;
    end
  end

  assign exc_err_o = exc_err_q;
`endif

  assign exc_req_o    = (state_q == ST_REQ);
  assign exc_num_o    = (state_q == ST_REQ) ? req_num_q : cur_num_q;
  assign clr_pend_o   = clr_pend_q;
  assign exec_prio_o  = exec_prio_q;
  assign nest_depth_o = nest_q;

endmodule

// File: tb/tb_nvic_exc_ctrl.sv
// tb/tb_nvic_exc_ctrl.sv - directed scoreboard bench for nvic_exc_ctrl
module tb_nvic_exc_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_pending;
  logic [31:0] irq_prio;
  logic        exc_ack;
  logic        exc_return;
  logic        exc_req;
  logic [2:0]  exc_num;
  logic [7:0]  clr_pend;
  logic [4:0]  exec_prio;
  logic [2:0]  nest_depth;
`ifdef NVIC_EXC_ERR_EN
  logic        exc_err;
`endif

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  nvic_exc_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .irq_pending_i (irq_pending),
    .irq_prio_i    (irq_prio),
    .exc_ack_i     (exc_ack),
    .exc_return_i  (exc_return),
    .exc_req_o     (exc_req),
    .exc_num_o     (exc_num),
    .clr_pend_o    (clr_pend),
    .exec_prio_o   (exec_prio),
    .nest_depth_o  (nest_depth)
`ifdef NVIC_EXC_ERR_EN
    ,
    .exc_err_o     (exc_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h expected <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp_out(input string tag, input logic req, input logic [2:0] num,
                         input logic [7:0] clr, input logic [4:0] prio, input logic [2:0] dep);
    expect_v({tag, ".req"},  32'(req));
    expect_v({tag, ".num"},  32'(num));
    expect_v({tag, ".clr"},  32'(clr));
    expect_v({tag, ".prio"}, 32'(prio));
    expect_v({tag, ".dep"},  32'(dep));
  endtask

  task automatic obs_out();
    check(32'(exc_req));
    check(32'(exc_num));
    check(32'(clr_pend));
    check(32'(exec_prio));
    check(32'(nest_depth));
  endtask

  // Take one IRQ from pending through ack into RUN, then release its pending bit
  task automatic enter(input string tag, input int irq, input logic [4:0] prio,
                       input logic [2:0] dep, input logic [4:0] prev_prio,
                       input logic [2:0] prev_num);
    irq_pending = 8'(1) << irq;
    exp_out({tag, "_req"}, 1'b1, 3'(irq), 8'h00, prev_prio, dep - 3'd1);
    step();
    obs_out();
    exc_ack = 1'b1;
    exp_out({tag, "_ack"}, 1'b0, 3'(irq), 8'(1) << irq, prio, dep);
    step();
    obs_out();
    exc_ack = 1'b0;
    irq_pending = 8'h00;
    exp_out({tag, "_run"}, 1'b0, 3'(irq), 8'h00, prio, dep);
    step();
    obs_out();
    if (prev_num > 3'd7) $display("unreachable");
  endtask

  // Return from the current handler, then let POP settle
  task automatic leave(input string tag, input logic [2:0] num,
                       input logic [4:0] prio, input logic [2:0] dep);
    exc_return = 1'b1;
    exp_out({tag, "_pop"}, 1'b0, num, 8'h00, prio, dep);
    step();
    obs_out();
    exc_return = 1'b0;
    exp_out({tag, "_set"}, 1'b0, num, 8'h00, prio, dep);
    step();
    obs_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    irq_pending = 8'h00;
    irq_prio    = 32'h0;
    exc_ack     = 1'b0;
    exc_return  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_out("reset", 1'b0, 3'd0, 8'h00, 5'h10, 3'd0);
    obs_out();
    rst = 1'b0;
    step();

    // Tie at priority 0 between IRQ1 and IRQ2 resolves to IRQ1
    irq_prio    = 32'h0000c008;
    irq_pending = 8'h06;
    exp_out("t1_req", 1'b1, 3'd1, 8'h00, 5'h10, 3'd0);
    step();
    obs_out();
    exc_ack = 1'b1;
    exp_out("t1_ack", 1'b0, 3'd1, 8'h02, 5'h00, 3'd1);
    step();
    obs_out();
    exc_ack     = 1'b0;
    irq_pending = 8'h00;
    exp_out("t1_run", 1'b0, 3'd1, 8'h00, 5'h00, 3'd1);
    step();
    obs_out();
    leave("t1_ret", 3'd0, 5'h10, 3'd0);

    // IRQ3 handler preempted by IRQ0, then unwound
    enter("t2a", 3, 5'h0c, 3'd1, 5'h10, 3'd0);
    enter("t2b", 0, 5'h08, 3'd2, 5'h0c, 3'd3);
    leave("t2r1", 3'd3, 5'h0c, 3'd1);
    leave("t2r2", 3'd0, 5'h10, 3'd0);

    // Pending withdrawn before ack
    irq_pending = 8'h01;
    exp_out("t3_req", 1'b1, 3'd0, 8'h00, 5'h10, 3'd0);
    step();
    obs_out();
    irq_pending = 8'h00;
    exp_out("t3_wd", 1'b0, 3'd0, 8'h00, 5'h10, 3'd0);
    step();
    obs_out();
    exp_out("t3_idle", 1'b0, 3'd0, 8'h00, 5'h10, 3'd0);
    step();
    obs_out();

    // Fill the stack with rising urgency, then a prio-0 IRQ must wait
    irq_prio = 32'h01234567;
    enter("t4a", 0, 5'h07, 3'd1, 5'h10, 3'd0);
    enter("t4b", 1, 5'h06, 3'd2, 5'h07, 3'd0);
    enter("t4c", 2, 5'h05, 3'd3, 5'h06, 3'd1);
    enter("t4d", 3, 5'h04, 3'd4, 5'h05, 3'd2);
    irq_pending = 8'h80;
    for (int i = 0; i < 3; i++) begin
      exp_out("t4_full", 1'b0, 3'd3, 8'h00, 5'h04, 3'd4);
      step();
      obs_out();
    end
    exc_return = 1'b1;
    exp_out("t4_pop", 1'b0, 3'd2, 8'h00, 5'h05, 3'd3);
    step();
    obs_out();
    exc_return = 1'b0;
    exp_out("t4_pop1", 1'b0, 3'd2, 8'h00, 5'h05, 3'd3);
    step();
    obs_out();
    exp_out("t4_req", 1'b1, 3'd7, 8'h00, 5'h05, 3'd3);
    step();
    obs_out();
    exc_ack = 1'b1;
    exp_out("t4_ack", 1'b0, 3'd7, 8'h80, 5'h00, 3'd4);
    step();
    obs_out();
    exc_ack     = 1'b0;
    irq_pending = 8'h00;
    step();
    leave("t4u1", 3'd2, 5'h05, 3'd3);
    leave("t4u2", 3'd1, 5'h06, 3'd2);
    leave("t4u3", 3'd0, 5'h07, 3'd1);
    leave("t4u4", 3'd0, 5'h10, 3'd0);

    // Return and a more urgent IRQ in the same RUN cycle: POP goes first
    enter("t5", 0, 5'h07, 3'd1, 5'h10, 3'd0);
    exc_return  = 1'b1;
    irq_pending = 8'h80;
    exp_out("t5_pop", 1'b0, 3'd0, 8'h00, 5'h10, 3'd0);
    step();
    obs_out();
    exc_return = 1'b0;
    exp_out("t5_wait", 1'b0, 3'd0, 8'h00, 5'h10, 3'd0);
    step();
    obs_out();
    exp_out("t5_req", 1'b1, 3'd7, 8'h00, 5'h10, 3'd0);
    step();
    obs_out();

    // Asynchronous reset while requesting
    rst = 1'b1;
    #1;
    exp_out("t6_rst", 1'b0, 3'd0, 8'h00, 5'h10, 3'd0);
    obs_out();
`ifdef NVIC_EXC_ERR_EN
    expect_v("t6_err_clr", 32'd0);
    check(32'(exc_err));
`endif
    irq_pending = 8'h00;
    step();
    rst = 1'b0;
    step();
    exp_out("t6_idle", 1'b0, 3'd0, 8'h00, 5'h10, 3'd0);
    obs_out();
`ifdef NVIC_EXC_ERR_EN
    exc_return = 1'b1;
    step();
    exc_return = 1'b0;
    expect_v("t6_err_set", 32'd1);
    check(32'(exc_err));
`endif

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
